mem_arbiter: RTL and testbench

Shares the single-port, byte-wide 4 KiB main memory between the CPU core and a debug/loader port. Each requester issues 8- or 16-bit little-endian reads and writes over a req/ack handshake. The arbiter sequences each 16-bit access as two byte cycles on the memory. It sits between the CPU's memory interface and the memory array, and replaces direct CPU access to the array.

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide memory between the CPU and debug ports.
// Build option MEM_ARB_RR_EN: round-robin ties; undefined gives debug priority.
module mem_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_word,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [15:0]       c_wdata,
  output logic [15:0]       c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_word,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic [15:0]       d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    FIN
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic              win_q;
  logic              we_q;
  logic              word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic              m_we_q;
  logic [7:0]        m_wdata_q;
  logic              c_ack_q;
  logic              d_ack_q;
  logic [7:0]        rd_lo_q;

  logic              any_req;
  logic              gnt_d;
  logic              sel_we;
  logic              sel_word;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic [15:0]       rd_bus;

  assign any_req = c_req | d_req;

`ifdef MEM_ARB_RR_EN
  // ptr_q names the requester that wins the next tie (0 = CPU)
  logic ptr_q;

  // tie goes to the pointer; a lone requester always wins
  always_comb begin
    gnt_d = d_req;
    if (c_req && d_req) begin
      gnt_d = ptr_q;
    end
  end

  // after every grant the other requester gets the next tie
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      ptr_q <= ~gnt_d;
    end
  end
`else
  // fixed priority: debug wins every tie
  always_comb begin
    gnt_d = d_req;
  end
`endif

  // mux the winning requester's command for the latch in IDLE
  always_comb begin
    sel_we    = c_we;
    sel_word  = c_word;
    sel_addr  = c_addr;
    sel_wdata = c_wdata;
    if (gnt_d) begin
      sel_we    = d_we;
      sel_word  = d_word;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
  end

  // access sequencer: latch, low byte, optional high byte, ack
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_addr_q  <= '0;
      m_we_q    <= 1'b0;
      m_wdata_q <= '0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      rd_lo_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= LO;
            win_q     <= gnt_d;
            we_q      <= sel_we;
            word_q    <= sel_word;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            m_addr_q  <= sel_addr;
            m_we_q    <= sel_we;
            m_wdata_q <= sel_wdata[7:0];
          end
        end
        LO: begin
          if (word_q) begin
            state_q   <= HI;
            m_addr_q  <= addr_q + ONE;
            m_we_q    <= we_q;
            m_wdata_q <= wdata_q[15:8];
          end else begin
            state_q <= FIN;
            m_we_q  <= 1'b0;
            c_ack_q <= ~win_q;
            d_ack_q <= win_q;
          end
        end
        HI: begin
          state_q <= FIN;
          rd_lo_q <= m_rdata;
          m_we_q  <= 1'b0;
          c_ack_q <= ~win_q;
          d_ack_q <= win_q;
        end
        FIN: begin
          state_q <= IDLE;
          c_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The memory returns a byte one cycle after its address, so during
  // FIN the last byte is still on m_rdata; it is forwarded alongside
  // the low byte captured in HI rather than waiting another cycle.
  always_comb begin
    rd_bus = {8'h00, m_rdata};
    if (word_q) begin
      rd_bus = {m_rdata, rd_lo_q};
    end
  end

  assign c_ack   = c_ack_q;
  assign d_ack   = d_ack_q;
  assign c_rdata = c_ack_q ? rd_bus : 16'h0000;
  assign d_rdata = d_ack_q ? rd_bus : 16'h0000;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  // a reset arriving mid-access must suppress the pending byte write
  assign m_we    = m_we_q & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard bench for mem_arbiter.
// Holds a byte-wide registered-read memory model behind the arbiter.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        c_req, c_we, c_word;
  logic [11:0] c_addr;
  logic [15:0] c_wdata, c_rdata;
  logic        c_ack;
  logic        d_req, d_we, d_word;
  logic [11:0] d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic        d_ack;
  logic [11:0] m_addr;
  logic        m_we;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata = 8'h00;

  mem_arbiter #(.ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_word(c_word),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_word(d_word),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic        we;
    logic        word;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        port;
    logic        rd;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    int          cyc;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] mem [4096] = '{default: 8'h00};
  int  cyc = 0;
  wr_t wlog[$];
  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (m_we) begin
      mem[m_addr] <= m_wdata;
      wlog.push_back('{cyc + 1, m_addr, m_wdata});
    end
    m_rdata <= mem[m_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input vec_t v);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_word = v.word;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1'b1; c_we = v.we; c_word = v.word;
      c_addr = v.addr; c_wdata = v.wdata;
    end
    sb_q.push_back('{v.port, !v.we, v.exp});
  endtask

  task automatic score();
    sb_t e;
    chk("ack_excl", {63'd0, c_ack & d_ack}, 64'd0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty got ack with no pending request");
    end else begin
      e = sb_q.pop_front();
      chk("ack_port", {63'd0, d_ack}, {63'd0, e.port});
      if (e.rd) begin
        chk("rdata", {48'd0, d_ack ? d_rdata : c_rdata},
            {48'd0, e.exp});
      end
    end
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    while (k < 12) begin
      @(negedge clock);
      k++;
      if (c_ack || d_ack) break;
    end
    if (!(c_ack || d_ack)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got none want ack");
      k = -1;
    end else begin
      score();
    end
  endtask

  task automatic run_txn(input vec_t v, output int n);
    int k;
    @(posedge clock); #1;
    c_req = 1'b0;
    d_req = 1'b0;
    set_port(v);
    @(posedge clock); #1;
    n = cyc;
    wait_ack(k);
    chk("latency", k, v.word ? 3 : 2);
    @(negedge clock);
    c_req = 1'b0;
    d_req = 1'b0;
    chk("ack_pulse", {63'd0, c_ack | d_ack}, 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return {9'd0, c_ack, d_ack, m_we, m_addr, m_wdata,
            c_rdata, d_rdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  vec_t tbl[10];
  int   order[5];

  initial begin
    int n, k, base, tc, td;
    logic seen;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 12'h010, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0012};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0034};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 12'h100, 16'hC35A, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 12'h100, 16'h0000, 16'h005A};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 12'h011, 16'h0000, 16'h00BE};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 12'h0FF, 16'h7788, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 12'h0FF, 16'h0000, 16'h7788};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 12'hFFF, 16'h0000, 16'h1234};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 12'h101, 16'h0000, 16'h0000};
`ifdef MEM_ARB_RR_EN
    order = '{0, 1, 0, 1, 0};
`else
    order = '{1, 1, 1, 1, 0};
`endif

    reset = 1'b1;
    c_req = 0; c_we = 0; c_word = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_word = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_outs", outs(), 64'd0);

    base = wlog.size();
    run_txn('{1'b0, 1'b1, 1'b1, 12'h010, 16'hBEEF, 16'h0}, n);
    chk("wr_count", wlog.size() - base, 2);
    if (wlog.size() - base == 2) begin
      chk("wr_lo", {wlog[base].cyc, 12'd0, wlog[base].a,
                    wlog[base].d},
          {n + 1, 12'd0, 12'h010, 8'hEF});
      chk("wr_hi", {wlog[base+1].cyc, 12'd0, wlog[base+1].a,
                    wlog[base+1].d},
          {n + 2, 12'd0, 12'h011, 8'hBE});
    end

    base = wlog.size();
    run_txn('{1'b1, 1'b1, 1'b1, 12'hFFF, 16'h1234, 16'h0}, n);
    chk("wrap_count", wlog.size() - base, 2);
    if (wlog.size() - base == 2) begin
      chk("wrap_lo", {wlog[base].a, wlog[base].d},
          {12'hFFF, 8'h34});
      chk("wrap_hi", {wlog[base+1].a, wlog[base+1].d},
          {12'h000, 8'h12});
    end

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], n);
    end

    @(posedge clock); #1;
    c_req = 1; c_we = 0; c_word = 1; c_addr = 12'h010;
    d_req = 1; d_we = 0; d_word = 1; d_addr = 12'h0FF;
    for (int g = 0; g < 5; g++) begin
      sb_q.push_back('{order[g][0], 1'b1,
                      order[g][0] ? 16'h7788 : 16'hBEEF});
    end
    for (int g = 0; g < 5; g++) begin
      wait_ack(k);
      if (g == 3) d_req = 1'b0;
      if (g == 4) c_req = 1'b0;
    end

    base = wlog.size();
    @(posedge clock); #1;
    set_port('{1'b0, 1'b1, 1'b1, 12'h030, 16'h1357, 16'h0});
    @(posedge clock); #1;
    set_port('{1'b1, 1'b0, 1'b1, 12'h030, 16'h0000, 16'h1357});
    c_addr = 12'h555; c_wdata = 16'hFFFF; c_we = 0; c_word = 0;
    wait_ack(k);
    chk("holdoff_c_lat", k, 3);
    tc = cyc;
    c_req = 1'b0;
    wait_ack(k);
    td = cyc;
    d_req = 1'b0;
    chk("holdoff_gap", td - tc, 4);
    chk("holdoff_wr", wlog.size() - base, 2);

    base = wlog.size();
    @(posedge clock); #1;
    c_req = 1; c_we = 1; c_word = 1;
    c_addr = 12'h020; c_wdata = 16'hAAAA;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    c_req = 1'b0;
    @(negedge clock);
    chk("rst_we_gate", {63'd0, m_we}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_outs", outs(), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen = seen | c_ack | d_ack;
    end
    chk("rst_no_ack", {63'd0, seen}, 64'd0);
    chk("rst_wr_count", wlog.size() - base, 1);
    if (wlog.size() - base == 1) begin
      chk("rst_wr_lo", {wlog[base].a, wlog[base].d},
          {12'h020, 8'hAA});
    end
    run_txn('{1'b1, 1'b0, 1'b1, 12'h020, 16'h0, 16'h00AA}, n);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
